fetch_queue_unit: RTL and testbench

// - Next-gen instruction fetch stage: PC generation, pipelined requests to an instruction memory with

---
 rtl/fetch_queue_unit_pkg.sv | 18 +
 rtl/fetch_queue_unit_if.sv | 31 +++
 rtl/fetch_queue_unit_fetch_fifo.sv | 56 +++++
 rtl/fetch_queue_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue unit: entry layout, instruction size, PC alignment.
package fetch_queue_unit_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; redirect targets drop their two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-side bundle: execute redirect, instruction memory request/response and decode handshake.
interface fetch_queue_unit_if;
  import fetch_queue_unit_pkg::*;

  // Execute bundle
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  // Instruction memory
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  // Fetch bundle towards decode
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc4;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc4
  );

endinterface

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; push at full is accepted only alongside a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // NOTE: storage has no reset; pointers and count alone decide which words are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generation, pipelined imem requests with credit-based flow control, fetch queue to decode.
// Optional FETCH_PERF_EN adds fetched/dropped/stall performance counters.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              QDEPTH          = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR    = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fetch_queue_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]     o_perf_fetched,
  output logic [XLEN-1:0]     o_perf_dropped,
  output logic [XLEN-1:0]     o_perf_stall
`endif
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int EW  = $bits(fetch_entry_t);

  logic [XLEN-1:0] r_pc;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   r_drop;
  logic [OW-1:0]   w_out_next;

  logic            w_redirect;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_rsp_keep;
  logic            w_dec_valid;
  logic            w_pop;

  fetch_entry_t    w_q_in;
  fetch_entry_t    w_q_head;
  logic            w_q_full;
  logic            w_q_empty;
  logic [QCW-1:0]  w_q_count;

  logic [XLEN-1:0] w_pcq_head;
  logic            w_pcq_full;
  logic            w_pcq_empty;
  logic [OW-1:0]   w_pcq_count;

  assign w_redirect  = bus.redirect_valid;
  // Credit rule: a request is only issued when its response is guaranteed a queue slot.
  assign w_req_valid = !i_reset && !w_redirect &&
                       (int'(r_outstanding) < MAX_OUTSTANDING) &&
                       (int'(w_q_count) + int'(r_outstanding) < QDEPTH);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_rsp       = bus.imem_rsp_valid;
  assign w_rsp_keep  = w_rsp && (r_drop == '0) && !w_redirect;
  assign w_dec_valid = !i_reset && !w_q_empty;
  assign w_pop       = w_dec_valid && bus.dec_ready && !w_redirect;
  assign w_out_next  = r_outstanding + OW'(w_req_fire) - OW'(w_rsp);

  assign w_q_in = '{pc: w_pcq_head, instr: bus.imem_rsp_data};

  fetch_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_queue (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rsp_keep),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_q_in),
    .o_data  (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // Request PCs in flight; survives redirects because dropped responses still retire their PC.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp),
    .i_flush (1'b0),
    .i_data  (r_pc),
    .o_data  (w_pcq_head),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty),
    .o_count (w_pcq_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        r_pc   <= align_pc(bus.redirect_pc);
        r_drop <= w_out_next;
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(INSTR_BYTES);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - OW'(1);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.dec_valid      = w_dec_valid;
  assign bus.dec_instr      = w_dec_valid ? w_q_head.instr : NOP_INSTR;
  assign bus.dec_pc         = w_q_head.pc;
  assign bus.dec_pc4        = w_q_head.pc + XLEN'(INSTR_BYTES);

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] r_perf_fetched;
  logic [XLEN-1:0] r_perf_dropped;
  logic [XLEN-1:0] r_perf_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + XLEN'(w_rsp_keep);
      r_perf_dropped <= r_perf_dropped + XLEN'(w_rsp && !w_rsp_keep);
      r_perf_stall   <= r_perf_stall + XLEN'(!w_dec_valid);
    end
  end

  assign o_perf_fetched = r_perf_fetched;
  assign o_perf_dropped = r_perf_dropped;
  assign o_perf_stall   = r_perf_stall;
`endif

  // Environment and bookkeeping invariants.
  a_rsp_has_request: assert property (@(posedge i_clk) disable iff (i_reset)
    w_rsp |-> (r_outstanding != '0) && !w_pcq_empty);
  a_drop_bounded: assert property (@(posedge i_clk) disable iff (i_reset)
    r_drop <= r_outstanding);
  a_pc_fifo_tracks: assert property (@(posedge i_clk) disable iff (i_reset)
    w_pcq_count == r_outstanding);
  a_no_pc_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_pcq_full && w_req_fire));
  a_no_queue_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(w_q_full && w_rsp_keep && !w_pop));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: transaction-level model with epoch-tagged memory and expected queue.
module tb_fetch_queue_unit;
  import fetch_queue_unit_pkg::*;

  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_unit_if fi ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  fetch_queue_unit #(.QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_VECTOR(32'h0)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (fi)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched (perf_fetched),
    .o_perf_dropped (perf_dropped),
    .o_perf_stall   (perf_stall)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          rdy;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  popped[$];
  logic [31:0]  m_pc;
  int           m_epoch, cyc;
  int           m_fetched, m_dropped, m_stall;

  int k_dec_pct = 100, k_rdy_pct = 100, k_rsp_pct = 100;
  int k_lat_min = 1, k_lat_max = 1, k_redir_pct = 0;

  logic        s_req_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Inputs for the next cycle, applied just after the active edge.
  task automatic drive_next();
    cyc++;
    fi.dec_ready      = chance(k_dec_pct);
    fi.imem_req_ready = chance(k_rdy_pct);
    fi.redirect_valid = chance(k_redir_pct);
    fi.redirect_pc    = $urandom();
    if (mem_q.size() > 0 && mem_q[0].rdy <= cyc && chance(k_rsp_pct)) begin
      fi.imem_rsp_valid = 1'b1;
      fi.imem_rsp_data  = mem_q[0].data;
    end else begin
      fi.imem_rsp_valid = 1'b0;
      fi.imem_rsp_data  = $urandom();
    end
  endtask

  // One clock cycle: compare outputs against the model, advance the model, drive next inputs.
  task automatic step();
    bit           exp_req, exp_dec, fire, pop;
    mreq_t        r;
    fetch_entry_t e;
    @(negedge clk);
    exp_req = !fi.redirect_valid && (mem_q.size() < MAX_OUT) &&
              (exp_q.size() + mem_q.size() < QDEPTH);
    exp_dec = exp_q.size() != 0;
    s_req_valid = fi.imem_req_valid;
    s_req_addr  = fi.imem_req_addr;
    s_dec_valid = fi.dec_valid;
    s_dec_pc    = fi.dec_pc;
    check("req_valid", fi.imem_req_valid, exp_req);
    if (fi.imem_req_valid) check("req_addr", fi.imem_req_addr, m_pc);
    check("dec_valid", fi.dec_valid, exp_dec);
    if (exp_dec && fi.dec_valid) begin
      check("dec_pc", fi.dec_pc, exp_q[0].pc);
      check("dec_instr", fi.dec_instr, exp_q[0].instr);
    end
    fire = fi.imem_req_valid && fi.imem_req_ready;
    pop  = exp_dec && fi.dec_ready && !fi.redirect_valid;
    if (pop) begin
      check("dec_pc4", fi.dec_pc4, exp_q[0].pc + 32'd4);
      popped.push_back(fi.dec_pc);
    end
    if (!exp_dec) m_stall++;
    if (fire) begin
      r.addr  = m_pc;
      r.data  = $urandom();
      r.epoch = m_epoch;
      r.rdy   = cyc + int'($urandom_range(k_lat_max, k_lat_min));
      mem_q.push_back(r);
      m_pc = m_pc + 32'd4;
    end
    if (pop) void'(exp_q.pop_front());
    if (fi.imem_rsp_valid) begin
      r = mem_q.pop_front();
      if (r.epoch == m_epoch && !fi.redirect_valid) begin
        e.pc    = r.addr;
        e.instr = r.data;
        exp_q.push_back(e);
        m_fetched++;
      end else begin
        m_dropped++;
      end
    end
    if (fi.redirect_valid) begin
      exp_q.delete();
      m_epoch++;
      m_pc = fi.redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    drive_next();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    fi.redirect_valid = 1'b0;
    fi.redirect_pc    = '0;
    fi.imem_req_ready = 1'b0;
    fi.imem_rsp_valid = 1'b0;
    fi.imem_rsp_data  = '0;
    fi.dec_ready      = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_req_valid", fi.imem_req_valid, 1'b0);
      check("rst_dec_valid", fi.dec_valid, 1'b0);
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    mem_q.delete();
    exp_q.delete();
    popped.delete();
    m_pc = 32'h0;
    m_epoch = 0;
    m_fetched = 0;
    m_dropped = 0;
    m_stall = 0;
    cyc = -1;
    drive_next();
  endtask

  task automatic wait_dec(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_dec_valid && n < 100);
    check({tag, "_valid"}, s_dec_valid, 1'b1);
    if (s_dec_valid) check(tag, s_dec_pc, exp_pc);
  endtask

  task automatic set_knobs(input int dec, input int rdy, input int lmin, input int lmax);
    k_dec_pct = dec;
    k_rdy_pct = rdy;
    k_rsp_pct = 100;
    k_lat_min = lmin;
    k_lat_max = lmax;
    k_redir_pct = 0;
  endtask

  initial begin
    int first;
    bit found;

    // Streaming from reset with a 1-cycle memory
    set_knobs(100, 100, 1, 1);
    do_reset(3);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_dec_valid && first < 0) begin
        first = i;
        check("first_dec_pc", s_dec_pc, 32'h0);
      end
    end
    check("first_valid_cycle", first, 32'd2);

    // Decode stalled: queue fills to depth, requests stop, then drains in order
    set_knobs(0, 100, 1, 1);
    do_reset(2);
    repeat (12) step();
    check("fill_req_valid", s_req_valid, 1'b0);
    check("fill_dec_valid", s_dec_valid, 1'b1);
    popped.delete();
    k_dec_pct = 100;
    fi.dec_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++)
      check($sformatf("drain%0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Memory refuses requests for 5 cycles while address 0x8 is pending
    set_knobs(100, 100, 1, 1);
    do_reset(2);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      fi.imem_req_ready = 1'b0;
      step();
      check("stall_valid", s_req_valid, 1'b1);
      check("stall_addr", s_req_addr, 32'h8);
    end
    repeat (10) step();
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_seq%0d", i), (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Redirect with two requests in flight: both responses dropped, target aligned
    set_knobs(100, 100, 3, 3);
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = (mem_q.size() == 2) && (mem_q[0].addr == 32'h10);
    end
    check("inflight_setup", found, 1'b1);
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h103;
    step();
    wait_dec("redir_pc", 32'h100);

    // Redirect coinciding with pop and response, then a second redirect
    set_knobs(100, 100, 1, 1);
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = (exp_q.size() > 0) && fi.imem_rsp_valid && fi.dec_ready;
    end
    check("coincide_setup", found, 1'b1);
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h200;
    step();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'h300;
    step();
    check("flush_empty", s_dec_valid, 1'b0);
    wait_dec("redir2_pc", 32'h300);

    // PC wrap at the top of the address space
    set_knobs(100, 100, 1, 1);
    do_reset(2);
    step();
    fi.redirect_valid = 1'b1;
    fi.redirect_pc    = 32'hFFFF_FFFF;
    step();
    step();
    check("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", s_req_addr, 32'h0);
    wait_dec("wrap_pc", 32'hFFFF_FFFC);

    // Reset with two requests in flight leaves no stale entries
    set_knobs(100, 100, 3, 3);
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = (mem_q.size() == 2);
    end
    check("reset_inflight_setup", found, 1'b1);
    k_lat_min = 1;
    k_lat_max = 1;
    do_reset(2);
    wait_dec("post_reset_pc", 32'h0);

    // Randomized traffic
    for (int blk = 0; blk < 12; blk++) begin
      k_dec_pct   = int'($urandom_range(100, 20));
      k_rdy_pct   = int'($urandom_range(100, 20));
      k_rsp_pct   = int'($urandom_range(100, 30));
      k_lat_min   = int'($urandom_range(2, 1));
      k_lat_max   = k_lat_min + int'($urandom_range(4, 0));
      k_redir_pct = int'($urandom_range(5, 0));
      if (blk % 4 == 0) do_reset(int'($urandom_range(3, 1)));
      repeat (400) step();
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_dropped", perf_dropped, 32'(m_dropped));
    check("perf_stall", perf_stall, 32'(m_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
